// File: rtl/lc3b_pkg.sv
// Shared LC-3b register-file constants and the arbiter state encoding.
package lc3b_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    PRI_A  = 2'd0,
    PRI_B  = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant with a B-side lock and a starvation safety counter.
module rr_grant2
  import lc3b_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req_i,
  input  logic       b_req_i,
  input  logic       b_lock_i,
  output logic       a_gnt_o,
  output logic       b_gnt_o,
  output arb_state_e state_o
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PRI_A;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grants are forced low while reset is asserted so nothing leaks to the register file.
  always_comb begin
    a_gnt_o  = 1'b0;
    b_gnt_o  = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    if (rst_n) begin
      if (state_q == LOCK_B) begin
        b_gnt_o = b_req_i;
      end else if (b_req_i && (starve_q == STARVE_LIM)) begin
        b_gnt_o = 1'b1;
      end else if (a_req_i && b_req_i) begin
        a_gnt_o = (state_q == PRI_A);
        b_gnt_o = (state_q != PRI_A);
      end else begin
        a_gnt_o = a_req_i;
        b_gnt_o = b_req_i;
      end

      if (b_gnt_o) begin
        starve_d = '0;
      end else if (a_gnt_o && b_req_i && (starve_q != STARVE_LIM)) begin
        starve_d = starve_q + 1'b1;
      end

      if (b_gnt_o && b_lock_i) begin
        state_d = LOCK_B;
      end else begin
        unique case (state_q)
          PRI_A:   if (a_gnt_o && b_req_i) state_d = PRI_B;
          PRI_B:   if (b_gnt_o) state_d = PRI_A;
          LOCK_B:  if (!b_lock_i) state_d = PRI_A;
          default: state_d = PRI_A;
        endcase
      end
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/regfile_arbiter.sv
// Shares the LC-3b 8x16 register file between the core sequencer (A) and the debug port (B).
module regfile_arbiter
  import lc3b_pkg::*;
#(
  parameter int DATA_W     = lc3b_pkg::DATA_W,
  parameter int ADDR_W     = lc3b_pkg::ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_dr,
  input  logic [ADDR_W-1:0] a_sr1,
  input  logic [ADDR_W-1:0] a_sr2,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_dr,
  input  logic [ADDR_W-1:0] b_sr1,
  input  logic [ADDR_W-1:0] b_sr2,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic              rf_ld_reg,
  output logic [ADDR_W-1:0] rf_dr,
  output logic [ADDR_W-1:0] rf_sr1,
  output logic [ADDR_W-1:0] rf_sr2,
  output logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] rf_sr1_out,
  input  logic [DATA_W-1:0] rf_sr2_out,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output arb_state_e        dbg_state
);
  // Handshake: x_req is a single-cycle offer; the access happens in the cycle x_gnt is
  // high (same cycle, combinational); read data returns next cycle with x_rvalid, no backpressure.
  logic              a_rvalid_q, b_rvalid_q;
  logic [ADDR_W-1:0] dr_q, sr1_q, sr2_q;
  logic [DATA_W-1:0] data_q;

  rr_grant2 #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req_i (a_req),
    .b_req_i (b_req),
    .b_lock_i(b_lock),
    .a_gnt_o (a_gnt),
    .b_gnt_o (b_gnt),
    .state_o (dbg_state)
  );

  // With no grant the address/data lines hold their previous value.
  always_comb begin
    rf_ld_reg = 1'b0;
    rf_dr     = dr_q;
    rf_sr1    = sr1_q;
    rf_sr2    = sr2_q;
    rf_data   = data_q;
    if (b_gnt) begin
      rf_ld_reg = b_we;
      rf_dr     = b_dr;
      rf_sr1    = b_sr1;
      rf_sr2    = b_sr2;
      rf_data   = b_data;
    end else if (a_gnt) begin
      rf_ld_reg = a_we;
      rf_dr     = a_dr;
      rf_sr1    = a_sr1;
      rf_sr2    = a_sr2;
      rf_data   = a_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      dr_q       <= '0;
      sr1_q      <= '0;
      sr2_q      <= '0;
      data_q     <= '0;
    end else begin
      a_rvalid_q <= a_gnt;
      b_rvalid_q <= b_gnt;
      dr_q       <= rf_dr;
      sr1_q      <= rf_sr1;
      sr2_q      <= rf_sr2;
      data_q     <= rf_data;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign rd1      = rf_sr1_out;
  assign rd2      = rf_sr2_out;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural registered-read register file.
module tb_regfile_arbiter;
  import lc3b_pkg::*;

  logic        clk, rst_n;
  logic        a_req, a_we, b_req, b_we, b_lock;
  logic [2:0]  a_dr, a_sr1, a_sr2, b_dr, b_sr1, b_sr2;
  logic [15:0] a_data, b_data;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, rf_ld_reg;
  logic [2:0]  rf_dr, rf_sr1, rf_sr2;
  logic [15:0] rf_data, rf_sr1_out, rf_sr2_out, rd1, rd2;
  arb_state_e  dbg_state;

  logic [15:0] rf_mem [8];
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_dr(a_dr), .a_sr1(a_sr1), .a_sr2(a_sr2),
    .a_data(a_data), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_dr(b_dr), .b_sr1(b_sr1), .b_sr2(b_sr2),
    .b_data(b_data), .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rf_ld_reg(rf_ld_reg), .rf_dr(rf_dr), .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
    .rf_data(rf_data), .rf_sr1_out(rf_sr1_out), .rf_sr2_out(rf_sr2_out),
    .rd1(rd1), .rd2(rd2), .dbg_state(dbg_state)
  );

  // External register file: registered reads, read-before-write, no reset.
  always @(posedge clk) begin
    rf_sr1_out <= rf_mem[rf_sr1];
    rf_sr2_out <= rf_mem[rf_sr2];
    if (rf_ld_reg) rf_mem[rf_dr] <= rf_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_a(input logic req, input logic we, input logic [2:0] dr,
                       input logic [2:0] s1, input logic [2:0] s2, input logic [15:0] d);
    a_req = req; a_we = we; a_dr = dr; a_sr1 = s1; a_sr2 = s2; a_data = d;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock, input logic [2:0] dr,
                       input logic [2:0] s1, input logic [2:0] s2, input logic [15:0] d);
    b_req = req; b_we = we; b_lock = lock; b_dr = dr; b_sr1 = s1; b_sr2 = s2; b_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic ag, input logic bg, input logic ld);
    chk({tag, "_a_gnt"}, {31'd0, a_gnt}, {31'd0, ag});
    chk({tag, "_b_gnt"}, {31'd0, b_gnt}, {31'd0, bg});
    chk({tag, "_ld"}, {31'd0, rf_ld_reg}, {31'd0, ld});
  endtask

  task automatic chk_rv(input string tag, input logic av, input logic bv);
    chk({tag, "_a_rvalid"}, {31'd0, a_rvalid}, {31'd0, av});
    chk({tag, "_b_rvalid"}, {31'd0, b_rvalid}, {31'd0, bv});
  endtask

  task automatic push_rd(input logic [15:0] e1, input logic [15:0] e2);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  // scoreboard: pop the expected read pair for the access granted last cycle
  task automatic chk_rd(input string tag);
    logic [15:0] e1, e2;
    if (exp_q.size() < 2) begin
      chk({tag, "_sb_empty"}, exp_q.size(), 2);
    end else begin
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      chk({tag, "_rd1"}, {16'd0, rd1}, {16'd0, e1});
      chk({tag, "_rd2"}, {16'd0, rd2}, {16'd0, e2});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(1, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_gnt("rst_hold", 0, 0, 0);
    chk_rv("rst_hold", 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    set_a(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_state", dbg_state, PRI_A);
    chk_gnt("rst_idle", 0, 0, 0);

    // preload through A: R3, R1, R2, R5
    tick(); set_a(1, 1, 3, 0, 0, 16'h1234); #1;
    chk_gnt("wr_r3", 1, 0, 1);
    chk("wr_r3_dr", rf_dr, 3);
    chk("wr_r3_data", rf_data, 16'h1234);
    tick(); set_a(1, 1, 1, 0, 0, 16'h1111); #1; chk_gnt("wr_r1", 1, 0, 1);
    tick(); set_a(1, 1, 2, 0, 0, 16'h2222); #1; chk_gnt("wr_r2", 1, 0, 1);
    tick(); set_a(1, 1, 5, 0, 0, 16'h0001); #1; chk_gnt("wr_r5", 1, 0, 1);

    // A reads back R3 / R1
    tick();
    chk_rv("wr_rv", 1, 0);
    set_a(1, 0, 0, 3, 1, 0); push_rd(16'h1234, 16'h1111); #1;
    chk_gnt("rd_a", 1, 0, 0);
    chk("rd_a_sr1", rf_sr1, 3);
    tick();
    chk_rv("rd_a", 1, 0); chk_rd("rd_a");
    set_a(0, 0, 0, 0, 0, 0); #1;
    chk_gnt("idle_hold", 0, 0, 0);
    chk("hold_sr1", rf_sr1, 3);
    chk("hold_sr2", rf_sr2, 1);

    // contention: A, B, A, B
    tick();
    chk_rv("c_pre", 0, 0);
    set_a(1, 0, 0, 1, 1, 0); set_b(1, 0, 0, 0, 2, 2, 0); #1;
    chk_gnt("c0", 1, 0, 0); push_rd(16'h1111, 16'h1111);
    tick(); chk_rv("c0", 1, 0); chk_rd("c0"); #1;
    chk_gnt("c1", 0, 1, 0); push_rd(16'h2222, 16'h2222);
    tick(); chk_rv("c1", 0, 1); chk_rd("c1"); #1;
    chk_gnt("c2", 1, 0, 0); push_rd(16'h1111, 16'h1111);
    tick(); chk_rv("c2", 1, 0); chk_rd("c2"); #1;
    chk_gnt("c3", 0, 1, 0); push_rd(16'h2222, 16'h2222);

    // lock: B takes and holds the register file
    tick(); chk_rv("c3", 0, 1); chk_rd("c3");
    set_a(0, 0, 0, 0, 0, 0); set_b(1, 0, 1, 0, 2, 2, 0); #1;
    chk_gnt("l0", 0, 1, 0); push_rd(16'h2222, 16'h2222);
    tick(); chk_rv("l0", 0, 1); chk_rd("l0");
    chk("l1_state", dbg_state, LOCK_B);
    set_a(1, 0, 0, 1, 1, 0); #1;
    chk_gnt("l1", 0, 1, 0); push_rd(16'h2222, 16'h2222);
    tick(); chk_rv("l1", 0, 1); chk_rd("l1");
    set_b(0, 0, 1, 0, 2, 2, 0); #1;
    chk_gnt("l2", 0, 0, 0);
    chk("l2_state", dbg_state, LOCK_B);
    tick(); chk_rv("l2", 0, 0);
    set_b(1, 0, 0, 0, 2, 2, 0); #1;
    chk_gnt("l3", 0, 1, 0); push_rd(16'h2222, 16'h2222);
    tick(); chk_rv("l3", 0, 1); chk_rd("l3");
    chk("l4_state", dbg_state, PRI_A);
    #1;
    chk_gnt("l4", 1, 0, 0); push_rd(16'h1111, 16'h1111);

    // B read-before-write on R5, winning a tie in PRI_B
    tick(); chk_rv("l4", 1, 0); chk_rd("l4");
    chk("srw_state", dbg_state, PRI_B);
    set_b(1, 1, 0, 5, 5, 3, 16'hBEEF); #1;
    chk_gnt("srw", 0, 1, 1);
    chk("srw_dr", rf_dr, 5);
    chk("srw_data", rf_data, 16'hBEEF);
    push_rd(16'h0001, 16'h1234);
    tick(); chk_rv("srw", 0, 1); chk_rd("srw");
    set_a(0, 0, 0, 0, 0, 0); set_b(1, 0, 0, 0, 5, 5, 0); #1;
    chk_gnt("srw_rd", 0, 1, 0); push_rd(16'hBEEF, 16'hBEEF);
    tick(); chk_rv("srw_rd", 0, 1); chk_rd("srw_rd");

    // two idle cycles
    set_b(0, 0, 0, 0, 0, 0, 0); #1;
    chk_gnt("idle0", 0, 0, 0);
    tick(); chk_rv("idle0", 0, 0); #1;
    chk_gnt("idle1", 0, 0, 0);
    chk("idle_sr1", rf_sr1, 5);
    tick(); chk_rv("idle1", 0, 0);
    set_a(1, 0, 0, 5, 3, 0); #1;
    chk_gnt("post_idle", 1, 0, 0); push_rd(16'hBEEF, 16'h1234);
    tick(); chk_rv("post_idle", 1, 0); chk_rd("post_idle");

    // reset asserted in the middle of a granted write
    set_a(1, 0, 0, 3, 3, 0); set_b(1, 0, 0, 0, 1, 1, 0); #1;
    chk_gnt("pre_rst", 1, 0, 0); push_rd(16'h1234, 16'h1234);
    tick(); chk_rv("pre_rst", 1, 0); chk_rd("pre_rst");
    chk("pre_rst_state", dbg_state, PRI_B);
    set_a(1, 1, 6, 0, 0, 16'hDEAD); set_b(0, 0, 0, 0, 0, 0, 0); #1;
    chk_gnt("mid_wr", 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_gnt("mid_rst", 0, 0, 0);
    chk_rv("mid_rst", 0, 0);
    chk("mid_rst_state", dbg_state, PRI_A);
    tick();
    tick();
    rst_n = 1'b1;
    set_a(1, 0, 0, 3, 3, 0); #1;
    chk_gnt("after_rst", 1, 0, 0); push_rd(16'h1234, 16'h1234);
    tick(); chk_rv("after_rst", 1, 0); chk_rd("after_rst");
    set_a(0, 0, 0, 0, 0, 0); #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the LC-3b 8x16 register file between two requesters: A (core datapath sequencer) and B (debug/monitor port).
- Each cycle, at most one requester is granted the register file's read pair and single write port.
- Handles the register file's 1-cycle registered read latency; returns read data with a per-requester valid.
- Supports a debug lock, so B can own the register file across multiple cycles (e.g. a halt-and-dump sequence).

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register index width (8 registers).
- STARVE_MAX, 4, maximum consecutive A grants while B is requesting before B is forced a grant.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  A requests an access this cycle.
- a_we  in  1  A access includes a write of a_data to a_dr.
- a_dr  in  ADDR_W  A destination register.
- a_sr1  in  ADDR_W  A source register 1.
- a_sr2  in  ADDR_W  A source register 2.
- a_data  in  DATA_W  A write data.
- a_gnt  out  1  A access accepted this cycle (combinational).
- a_rvalid  out  1  rd1/rd2 hold A's read result this cycle.
- b_req, b_we, b_dr, b_sr1, b_sr2, b_data: same as the A signals, for requester B.
- b_lock  in  1  while B is granted, keep the grant with B.
- b_gnt  out  1  B access accepted this cycle.
- b_rvalid  out  1  rd1/rd2 hold B's read result this cycle.
- rf_ld_reg  out  1  write enable to the register file.
- rf_dr, rf_sr1, rf_sr2  out  ADDR_W  register file address lines.
- rf_data  out  DATA_W  register file write data.
- rf_sr1_out, rf_sr2_out  in  DATA_W  registered read data from the register file.
- rd1, rd2  out  DATA_W  read data returned to the requester (pass-through of rf_sr1_out/rf_sr2_out).

Behaviour:
- Reset is asynchronous, active-low. Reset values: state=PRI_A, starve_cnt=0, a_rvalid=b_rvalid=0, grant registers=0. a_gnt, b_gnt and rf_ld_reg are therefore 0 during reset.
- FSM states:
  - PRI_A: A wins ties.
  - PRI_B: B wins ties.
  - LOCK_B: B only.
- Grant rule (combinational):
  - Only one requester requesting: that requester is granted.
  - Both requesting: the priority holder is granted.
  - LOCK_B: only B is granted; a_gnt=0 even if b_req=0.
- Grants are one-hot; no grant when neither requester is requesting.
- Mux: the granted requester's dr/sr1/sr2/data drive the rf_* outputs. rf_ld_reg = granted requester's we. With no grant, rf_ld_reg=0 and addresses hold their last value.
- Transitions:
  - PRI_A -> PRI_B after any A grant while b_req=1 (round-robin).
  - PRI_B -> PRI_A after a B grant.
  - Any state -> LOCK_B when b is granted with b_lock=1.
  - LOCK_B -> PRI_A on the first cycle with b_lock=0; the lock is released on that cycle, and B is still granted that cycle if b_req=1.
- Starvation: starve_cnt increments on each A grant while b_req=1 and clears on any B grant. When starve_cnt reaches STARVE_MAX, B is granted regardless of state. Round-robin already bounds waiting to 1 cycle; the counter is a safety net and must never fire in PRI_B.
- Read latency: data for a grant in cycle N appears on rd1/rd2 in cycle N+1, with the matching x_rvalid=1 for exactly one cycle. There is no response backpressure; the requester must accept the data.
- Write then read:
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later; no forwarding is needed.
  - A read and a write to the same register in the same grant return the old value (read-before-write).
- Back-to-back grants are allowed every cycle, alternating or repeated.
- Reset asserted mid-access clears rvalid immediately. Register file contents are untouched (the register file has no reset).
- Register file outputs are undefined before the first read; rvalid masks them.

Decomposition:
- Shared package lc3b_pkg: DATA_W=16, ADDR_W=3, NUM_REGS=8, and the arbiter state encoding (PRI_A, PRI_B, LOCK_B, 2 bits).
- Natural sub-module: rr_grant2, a 2-way round-robin grant with a lock input and the starve counter.
- The request/address mux and the rvalid pipeline stay in the top module.

Test Plan:
- Reset: rst_n=0 mid-cycle with a_req=1 -> a_gnt=0, rf_ld_reg=0, a_rvalid=0 immediately; state PRI_A after release.
- A alone: a_req=1, a_we=1, a_dr=3, a_data=16'h1234; next cycle a read of sr1=3 -> a_rvalid=1 on the following cycle with rd1=16'h1234.
- Contention: a_req=b_req=1 held for 4 cycles -> grants A, B, A, B; rvalid follows one cycle later with matching owner.
- Lock: B granted with b_lock=1 for 3 cycles while a_req=1 -> a_gnt=0 throughout; b_lock=0 -> B granted that cycle, A granted the next.
- Same-cycle read/write: B writes R5=16'hBEEF while reading sr1=5, with prior R5=16'h0001 -> rd1=16'h0001; a follow-up read -> 16'hBEEF.
- No request: a_req=b_req=0 for 2 cycles -> no grants, rf_ld_reg=0, both rvalid=0, register contents unchanged.
